// File: rtl/hazard_fwd_ctrl_pkg.sv
// Shared types and constants for the hazard/forwarding controller.
// Shadow tags are held at REG_AW_DEFAULT bits; narrower register indices are zero-extended.
package hazard_fwd_ctrl_pkg;

    localparam int unsigned REG_AW_DEFAULT = 5;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    typedef logic [REG_AW_DEFAULT-1:0] reg_idx_t;

    typedef struct packed {
        reg_idx_t rs1;
        reg_idx_t rs2;
        logic     use_rs1;
        logic     use_rs2;
        reg_idx_t rd;
        logic     regwrite;
        logic     memread;
    } idex_t;

    typedef struct packed {
        reg_idx_t rd;
        logic     regwrite;
        logic     memread;
    } exmem_t;

    typedef struct packed {
        reg_idx_t rd;
        logic     regwrite;
    } memwb_t;

endpackage

// File: rtl/hazard_fwd_ctrl_fwd_sel.sv
// Forwarding select for one EX operand: EX/MEM beats MEM/WB, x0 is never forwarded.
module fwd_sel
    import hazard_fwd_ctrl_pkg::*;
#(
    parameter int unsigned REG_AW = REG_AW_DEFAULT
) (
    input  logic [REG_AW-1:0] rs_i,
    input  logic              use_rs_i,
    input  logic [REG_AW-1:0] exmem_rd_i,
    input  logic              exmem_regwrite_i,
    input  logic [REG_AW-1:0] memwb_rd_i,
    input  logic              memwb_regwrite_i,
    output logic [1:0]        sel_o
);

    logic exmem_hit;
    logic memwb_hit;

    always_comb begin
        exmem_hit = use_rs_i && exmem_regwrite_i && (exmem_rd_i != '0) && (exmem_rd_i == rs_i);
        memwb_hit = use_rs_i && memwb_regwrite_i && (memwb_rd_i != '0) && (memwb_rd_i == rs_i);
        sel_o = FWD_RF;
        if (exmem_hit) begin
            sel_o = FWD_MEM;
        end else if (memwb_hit) begin
            sel_o = FWD_WB;
        end
    end

endmodule

// File: rtl/hazard_fwd_ctrl.sv
// Hazard and forwarding controller: shadow ID/EX, EX/MEM, MEM/WB tags, operand
// forwarding selects, load-use stall generation and a saturating stall counter.
module hazard_fwd_ctrl
    import hazard_fwd_ctrl_pkg::*;
#(
    parameter int unsigned REG_AW = REG_AW_DEFAULT,
    parameter int unsigned CNT_W  = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              id_valid_i,
    input  logic [REG_AW-1:0] id_rs1_i,
    input  logic [REG_AW-1:0] id_rs2_i,
    input  logic              id_use_rs1_i,
    input  logic              id_use_rs2_i,
    input  logic [REG_AW-1:0] id_rd_i,
    input  logic              id_regwrite_i,
    input  logic              id_memread_i,
    input  logic              flush_i,
    output logic [1:0]        fwd_a_o,
    output logic [1:0]        fwd_b_o,
    output logic              stall_o,
    output logic              pc_write_o,
    output logic              ifid_write_o,
    output logic [CNT_W-1:0]  stall_cnt_o
);

    idex_t            idex_q, idex_d;
    exmem_t           exmem_q, exmem_d;
    memwb_t           memwb_q, memwb_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    reg_idx_t id_rs1;
    reg_idx_t id_rs2;
    reg_idx_t id_rd;
    logic     load_use;
    logic     bubble;

    // EX/MEM memread is mirrored for completeness but nothing downstream consumes it.
    logic unused_exmem_memread;
    assign unused_exmem_memread = exmem_q.memread;

    always_comb begin
        id_rs1 = reg_idx_t'(id_rs1_i);
        id_rs2 = reg_idx_t'(id_rs2_i);
        id_rd  = reg_idx_t'(id_rd_i);

        load_use = id_valid_i && idex_q.memread && (idex_q.rd != '0) &&
                   ((id_use_rs1_i && (id_rs1 == idex_q.rd)) ||
                    (id_use_rs2_i && (id_rs2 == idex_q.rd)));
        // A flush discards the ID instruction, so a pending load-use stall is moot.
        stall_o      = load_use && !flush_i;
        pc_write_o   = !stall_o;
        ifid_write_o = !stall_o;
        bubble       = flush_i || stall_o || !id_valid_i;

        idex_d = '0;
        if (!bubble) begin
            idex_d.rs1      = id_rs1;
            idex_d.rs2      = id_rs2;
            idex_d.use_rs1  = id_use_rs1_i;
            idex_d.use_rs2  = id_use_rs2_i;
            idex_d.rd       = id_rd;
            idex_d.regwrite = id_regwrite_i;
            idex_d.memread  = id_memread_i;
        end

        exmem_d.rd       = idex_q.rd;
        exmem_d.regwrite = idex_q.regwrite;
        exmem_d.memread  = idex_q.memread;

        memwb_d.rd       = exmem_q.rd;
        memwb_d.regwrite = exmem_q.regwrite;

        stall_cnt_d = stall_cnt_q;
        if (stall_o && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            idex_q      <= '0;
            exmem_q     <= '0;
            memwb_q     <= '0;
            stall_cnt_q <= '0;
        end else begin
            idex_q      <= idex_d;
            exmem_q     <= exmem_d;
            memwb_q     <= memwb_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt_o = stall_cnt_q;

    fwd_sel #(
        .REG_AW (REG_AW_DEFAULT)
    ) u_fwd_a (
        .rs_i             (idex_q.rs1),
        .use_rs_i         (idex_q.use_rs1),
        .exmem_rd_i       (exmem_q.rd),
        .exmem_regwrite_i (exmem_q.regwrite),
        .memwb_rd_i       (memwb_q.rd),
        .memwb_regwrite_i (memwb_q.regwrite),
        .sel_o            (fwd_a_o)
    );

    fwd_sel #(
        .REG_AW (REG_AW_DEFAULT)
    ) u_fwd_b (
        .rs_i             (idex_q.rs2),
        .use_rs_i         (idex_q.use_rs2),
        .exmem_rd_i       (exmem_q.rd),
        .exmem_regwrite_i (exmem_q.regwrite),
        .memwb_rd_i       (memwb_q.rd),
        .memwb_regwrite_i (memwb_q.regwrite),
        .sel_o            (fwd_b_o)
    );

endmodule

// File: tb/tb_hazard_fwd_ctrl.sv
// Bench for hazard_fwd_ctrl: per-cycle vector table plus hand sequences for
// counter saturation and reset in the middle of a stall.
module tb_hazard_fwd_ctrl;

    localparam int unsigned CNT_W = 3;

    typedef struct {
        logic       v;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       u1;
        logic       u2;
        logic [4:0] rd;
        logic       rw;
        logic       mr;
        logic       fl;
        logic [1:0] ea;
        logic [1:0] eb;
        logic       es;
        int         ec;
    } row_t;

    typedef struct {
        logic [1:0]       a;
        logic [1:0]       b;
        logic             s;
        logic [CNT_W-1:0] c;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst_i;
    logic             id_valid_i;
    logic [4:0]       id_rs1_i;
    logic [4:0]       id_rs2_i;
    logic             id_use_rs1_i;
    logic             id_use_rs2_i;
    logic [4:0]       id_rd_i;
    logic             id_regwrite_i;
    logic             id_memread_i;
    logic             flush_i;
    logic [1:0]       fwd_a_o;
    logic [1:0]       fwd_b_o;
    logic             stall_o;
    logic             pc_write_o;
    logic             ifid_write_o;
    logic [CNT_W-1:0] stall_cnt_o;

    int   total = 0;
    int   bad   = 0;
    exp_t sb[$];
    row_t tbl[37];

    always #5 clk = ~clk;

    hazard_fwd_ctrl #(
        .REG_AW (5),
        .CNT_W  (CNT_W)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst_i),
        .id_valid_i    (id_valid_i),
        .id_rs1_i      (id_rs1_i),
        .id_rs2_i      (id_rs2_i),
        .id_use_rs1_i  (id_use_rs1_i),
        .id_use_rs2_i  (id_use_rs2_i),
        .id_rd_i       (id_rd_i),
        .id_regwrite_i (id_regwrite_i),
        .id_memread_i  (id_memread_i),
        .flush_i       (flush_i),
        .fwd_a_o       (fwd_a_o),
        .fwd_b_o       (fwd_b_o),
        .stall_o       (stall_o),
        .pc_write_o    (pc_write_o),
        .ifid_write_o  (ifid_write_o),
        .stall_cnt_o   (stall_cnt_o)
    );

    function automatic row_t mk(logic v, logic [4:0] rs1, logic [4:0] rs2, logic u1, logic u2,
                                logic [4:0] rd, logic rw, logic mr, logic fl,
                                logic [1:0] ea, logic [1:0] eb, logic es, int ec);
        row_t r;
        r.v = v;   r.rs1 = rs1; r.rs2 = rs2; r.u1 = u1; r.u2 = u2;
        r.rd = rd; r.rw = rw;   r.mr = mr;   r.fl = fl;
        r.ea = ea; r.eb = eb;   r.es = es;   r.ec = ec;
        return r;
    endfunction

    function automatic row_t alu(logic [4:0] rd, logic [4:0] rs1, logic [4:0] rs2,
                                 logic [1:0] ea, logic [1:0] eb, logic es, int ec);
        return mk(1'b1, rs1, rs2, 1'b1, 1'b1, rd, 1'b1, 1'b0, 1'b0, ea, eb, es, ec);
    endfunction

    function automatic row_t ld(logic [4:0] rd, logic [4:0] rs1,
                                logic [1:0] ea, logic [1:0] eb, logic es, int ec);
        return mk(1'b1, rs1, 5'd0, 1'b1, 1'b0, rd, 1'b1, 1'b1, 1'b0, ea, eb, es, ec);
    endfunction

    function automatic row_t nop(logic [1:0] ea, logic [1:0] eb, logic es, int ec);
        return mk(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, ea, eb, es, ec);
    endfunction

    task automatic check(string name, logic [31:0] got, logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, got, want);
        end
    endtask

    task automatic drive(row_t r);
        exp_t e;
        id_valid_i    = r.v;
        id_rs1_i      = r.rs1;
        id_rs2_i      = r.rs2;
        id_use_rs1_i  = r.u1;
        id_use_rs2_i  = r.u2;
        id_rd_i       = r.rd;
        id_regwrite_i = r.rw;
        id_memread_i  = r.mr;
        flush_i       = r.fl;
        e.a = r.ea;
        e.b = r.eb;
        e.s = r.es;
        e.c = CNT_W'(r.ec);
        sb.push_back(e);
    endtask

    // Compare at the falling edge, then advance past the next rising edge.
    task automatic sample(string tag);
        exp_t e;
        @(negedge clk);
        if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL %s scoreboard: got empty want entry", tag);
        end else begin
            e = sb.pop_front();
            check({tag, " fwd_a"}, 32'(fwd_a_o), 32'(e.a));
            check({tag, " fwd_b"}, 32'(fwd_b_o), 32'(e.b));
            check({tag, " stall"}, 32'(stall_o), 32'(e.s));
            check({tag, " pc_write"}, 32'(pc_write_o), 32'(!e.s));
            check({tag, " ifid_write"}, 32'(ifid_write_o), 32'(!e.s));
            check({tag, " stall_cnt"}, 32'(stall_cnt_o), 32'(e.c));
        end
        @(posedge clk);
        #1;
    endtask

    task automatic apply(row_t r, string tag);
        drive(r);
        sample(tag);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int c;
        row_t r;

        // ALU chain
        tbl[0]  = alu(5'd5, 5'd1, 5'd2, 2'b00, 2'b00, 1'b0, 0);
        tbl[1]  = alu(5'd6, 5'd5, 5'd7, 2'b00, 2'b00, 1'b0, 0);
        tbl[2]  = nop(2'b10, 2'b00, 1'b0, 0);
        tbl[3]  = nop(2'b00, 2'b00, 1'b0, 0);
        tbl[4]  = nop(2'b00, 2'b00, 1'b0, 0);
        // Two back, then EX/MEM priority over MEM/WB
        tbl[5]  = alu(5'd5, 5'd1, 5'd2, 2'b00, 2'b00, 1'b0, 0);
        tbl[6]  = nop(2'b00, 2'b00, 1'b0, 0);
        tbl[7]  = alu(5'd8, 5'd5, 5'd5, 2'b00, 2'b00, 1'b0, 0);
        tbl[8]  = nop(2'b01, 2'b01, 1'b0, 0);
        tbl[9]  = alu(5'd5, 5'd1, 5'd2, 2'b00, 2'b00, 1'b0, 0);
        tbl[10] = alu(5'd5, 5'd1, 5'd2, 2'b00, 2'b00, 1'b0, 0);
        tbl[11] = alu(5'd11, 5'd5, 5'd5, 2'b00, 2'b00, 1'b0, 0);
        tbl[12] = nop(2'b10, 2'b10, 1'b0, 0);
        tbl[13] = nop(2'b00, 2'b00, 1'b0, 0);
        tbl[14] = nop(2'b00, 2'b00, 1'b0, 0);
        // Load-use: dependent held in ID for the stall cycle
        tbl[15] = ld(5'd9, 5'd1, 2'b00, 2'b00, 1'b0, 0);
        tbl[16] = alu(5'd10, 5'd9, 5'd1, 2'b00, 2'b00, 1'b1, 0);
        tbl[17] = alu(5'd10, 5'd9, 5'd1, 2'b00, 2'b00, 1'b0, 1);
        tbl[18] = nop(2'b01, 2'b00, 1'b0, 1);
        tbl[19] = nop(2'b00, 2'b00, 1'b0, 1);
        tbl[20] = nop(2'b00, 2'b00, 1'b0, 1);
        // x0 destination, then load followed by an unused matching rs2
        tbl[21] = alu(5'd0, 5'd1, 5'd2, 2'b00, 2'b00, 1'b0, 1);
        tbl[22] = alu(5'd12, 5'd0, 5'd0, 2'b00, 2'b00, 1'b0, 1);
        tbl[23] = nop(2'b00, 2'b00, 1'b0, 1);
        tbl[24] = ld(5'd3, 5'd1, 2'b00, 2'b00, 1'b0, 1);
        tbl[25] = mk(1'b1, 5'd2, 5'd3, 1'b1, 1'b0, 5'd13, 1'b1, 1'b0, 1'b0,
                     2'b00, 2'b00, 1'b0, 1);
        tbl[26] = nop(2'b00, 2'b00, 1'b0, 1);
        tbl[27] = nop(2'b00, 2'b00, 1'b0, 1);
        tbl[28] = nop(2'b00, 2'b00, 1'b0, 1);
        // Flush overrides load-use; the flushed slot must not stall or forward
        tbl[29] = ld(5'd4, 5'd1, 2'b00, 2'b00, 1'b0, 1);
        tbl[30] = mk(1'b1, 5'd4, 5'd4, 1'b1, 1'b1, 5'd14, 1'b1, 1'b0, 1'b1,
                     2'b00, 2'b00, 1'b0, 1);
        tbl[31] = alu(5'd16, 5'd4, 5'd4, 2'b00, 2'b00, 1'b0, 1);
        tbl[32] = alu(5'd15, 5'd14, 5'd14, 2'b01, 2'b01, 1'b0, 1);
        tbl[33] = nop(2'b00, 2'b00, 1'b0, 1);
        tbl[34] = nop(2'b00, 2'b00, 1'b0, 1);
        tbl[35] = nop(2'b00, 2'b00, 1'b0, 1);
        tbl[36] = nop(2'b00, 2'b00, 1'b0, 1);

        // Reset held two cycles with arbitrary ID inputs
        rst_i = 1'b0;
        r = mk(1'($urandom), 5'($urandom), 5'($urandom), 1'($urandom), 1'($urandom),
               5'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 2'b00, 2'b00, 1'b0, 0);
        drive(r);
        void'(sb.pop_front());
        @(posedge clk);
        #1;
        r = mk(1'($urandom), 5'($urandom), 5'($urandom), 1'($urandom), 1'($urandom),
               5'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 2'b00, 2'b00, 1'b0, 0);
        drive(r);
        sample("reset");
        rst_i = 1'b1;

        for (int i = 0; i < 37; i++) begin
            apply(tbl[i], $sformatf("row%0d", i));
        end

        // Repeated load-use pairs drive the narrow counter into saturation
        c = 1;
        for (int k = 0; k < 8; k++) begin
            apply(ld(5'd9, 5'd1, 2'b00, 2'b00, 1'b0, c), $sformatf("sat%0d ld", k));
            apply(alu(5'd10, 5'd9, 5'd1, 2'b00, 2'b00, 1'b1, c), $sformatf("sat%0d stall", k));
            c = (c < 7) ? c + 1 : 7;
            apply(alu(5'd10, 5'd9, 5'd1, 2'b00, 2'b00, 1'b0, c), $sformatf("sat%0d held", k));
            apply(nop(2'b01, 2'b00, 1'b0, c), $sformatf("sat%0d fwd", k));
            apply(nop(2'b00, 2'b00, 1'b0, c), $sformatf("sat%0d nop1", k));
            apply(nop(2'b00, 2'b00, 1'b0, c), $sformatf("sat%0d nop2", k));
        end

        // Reset asserted while a load-use stall is active
        apply(ld(5'd9, 5'd1, 2'b00, 2'b00, 1'b0, 7), "rststall ld");
        rst_i = 1'b0;
        apply(alu(5'd10, 5'd9, 5'd1, 2'b00, 2'b00, 1'b1, 7), "rststall in");
        rst_i = 1'b1;
        apply(alu(5'd10, 5'd9, 5'd1, 2'b00, 2'b00, 1'b0, 0), "rststall out");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
